// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: instruction width, opcode encodings,
// and the fetch-stage state type.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_BL   = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

  // True when the top three instruction bits carry the HALT opcode.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[15:13] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register for the fetch stage. It catches the memory word
// that returns while the pipeline is frozen so the word is not lost.
// Priority: clear > load > drain.
module fetch_hold_buf
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               full
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               full_q, full_d;

  // Next-state for the skid entry; a squash wins over a capture.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    full_d  = full_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      instr_d = in_instr;
      pc_d    = in_pc;
      full_d  = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  // Skid entry registers, emptied by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      full_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      full_q  <= full_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign full  = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the 16-bit CPU. Owns the PC, reads the
// synchronous instruction memory (data one cycle after the strobe) and
// drives the IF/ID register. A one-entry hold buffer keeps the word that
// returns during a stall so nothing is lost or fetched twice. Fetch stops
// for good on a HALT instruction until reset.
// Optional build macro FETCH_PERF_EN adds saturating performance counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               pc_load,
  input  logic               flush,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_stall
`endif
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               pend_q, pend_d;
  logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;
  logic               if_id_valid_q, if_id_valid_d;

  logic               freeze;
  logic               squash;
  logic               issue;
  logic               running;

  logic               hold_load, hold_drain, hold_clear;
  logic [INSTR_W-1:0] hold_instr;
  logic [PC_W-1:0]    hold_pc;
  logic               hold_full;

  logic               load_ifid;
  logic [INSTR_W-1:0] load_instr;
  logic [PC_W-1:0]    load_pc;

  assign running = (state_q == FETCH_RUN);
  assign freeze  = stall | ~pc_load;
  assign squash  = flush | redirect;
  assign issue   = running & ~freeze & ~squash;

  assign imem_rd   = issue;
  assign imem_addr = pc_q;

  fetch_hold_buf #(
    .PC_W (PC_W)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hold_load),
    .drain    (hold_drain),
    .clear    (hold_clear),
    .in_instr (imem_rdata),
    .in_pc    (pend_pc_q),
    .instr    (hold_instr),
    .pc       (hold_pc),
    .full     (hold_full)
  );

  // PC sequencing: flush keeps the PC, redirect jumps, an issue steps by one
  // (wrapping naturally at 2^PC_W). Once halted the PC is left alone.
  always_comb begin
    pc_d      = pc_q;
    pend_d    = issue;
    pend_pc_d = pend_pc_q;
    if (running) begin
      if (flush) begin
        pc_d = pc_q;
      end else if (redirect) begin
        pc_d = redirect_pc;
      end else if (issue) begin
        pc_d      = pc_q + PC_W'(1);
        pend_pc_d = pc_q;
      end
    end
  end

  // IF/ID source selection and state transition. A squash kills the live
  // instruction and the skid entry; a frozen cycle parks any returning word
  // in the skid entry; the first thawed cycle prefers the skid entry over a
  // fresh return. Loading a HALT moves to the halted state, and in HALT the
  // IF/ID register keeps the HALT instruction while returns are dropped.
  always_comb begin
    state_d       = state_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    hold_load     = 1'b0;
    hold_drain    = 1'b0;
    hold_clear    = ~running;
    load_ifid     = 1'b0;
    load_instr    = imem_rdata;
    load_pc       = pend_pc_q;

    if (running) begin
      if (squash) begin
        if_id_valid_d = 1'b0;
        hold_clear    = 1'b1;
      end else if (freeze) begin
        hold_load = pend_q;
      end else if (hold_full) begin
        load_ifid  = 1'b1;
        load_instr = hold_instr;
        load_pc    = hold_pc;
        hold_drain = 1'b1;
      end else if (pend_q) begin
        load_ifid = 1'b1;
      end
    end

    if (load_ifid) begin
      if_id_instr_d = load_instr;
      if_id_pc_d    = load_pc;
      if_id_valid_d = 1'b1;
      if (is_halt(load_instr)) begin
        state_d = FETCH_HALT;
      end
    end
  end

  // Fetch-stage registers; reset aborts any outstanding read immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_RUN;
      pc_q          <= PC_W'(RESET_PC);
      pend_q        <= 1'b0;
      pend_pc_q     <= '0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = (state_q == FETCH_HALT);

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  // Saturating counters of IF/ID loads and frozen cycles, idle once halted.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (running) begin
      if (load_ifid && (perf_fetched_q != 16'hFFFF)) begin
        perf_fetched_d = perf_fetched_q + 16'd1;
      end
      if (freeze && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_d = perf_stall_q + 16'd1;
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
